// File: rtl/plcp_preamble_tx_if.sv
// Bus between the PPDU framer and its requester / payload source / spreader.
interface plcp_preamble_tx_if;
  logic        start;
  logic [15:0] length_us;
  logic        pay_bit;
  logic        pay_valid;
  logic        pay_ready;
  logic        tx_bit;
  logic        tx_valid;
  logic        busy;
  logic        tx_done;
  logic        underrun;

  // Requester side: issues frames, supplies payload, consumes the bit stream.
  modport master (
    output start, length_us, pay_bit, pay_valid,
    input  pay_ready, tx_bit, tx_valid, busy, tx_done, underrun
  );

  // Framer side.
  modport slave (
    input  start, length_us, pay_bit, pay_valid,
    output pay_ready, tx_bit, tx_valid, busy, tx_done, underrun
  );
endinterface

// File: rtl/plcp_preamble_tx.sv
// 802.11b 1 Mbps long-preamble PPDU framer: SYNC, SFD, PLCP header, CRC-16,
// then payload bits, emitted bit-serially with one strobe per bit period.
module plcp_preamble_tx #(
  parameter int unsigned BIT_PERIOD  = 11,
  parameter int unsigned SYNC_LEN    = 128,
  parameter logic [15:0] SFD_VAL     = 16'hF3A0,
  parameter logic [7:0]  SIGNAL_VAL  = 8'h0A,
  parameter logic [7:0]  SERVICE_VAL = 8'h00
) (
  input  logic               clk,
  input  logic               reset,
  plcp_preamble_tx_if.slave  bus
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned FLD_W = 8;
  localparam int unsigned LEN_W = 16;
  localparam int unsigned CRC_W = 16;
  localparam int unsigned HDR_W = 32;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_PERIOD - 1);
  localparam logic [FLD_W-1:0] SYNC_LAST = FLD_W'(SYNC_LEN - 1);
  localparam logic [CRC_W-1:0] CRC_INIT  = 16'hFFFF;
  localparam logic [CRC_W-1:0] CRC_POLY  = 16'h1021;

  typedef enum logic [2:0] {IDLE, SYNC, SFD, HDR, CRC, PAY} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FLD_W-1:0]   fcnt_q, fcnt_d, fcnt_inc;
  logic [LEN_W-1:0]   pcnt_q, pcnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CRC_W-1:0]   crc_q, crc_d, crc_nxt;
  logic               tx_bit_q, tx_bit_d;
  logic               tx_valid_q, tx_valid_d;
  logic               busy_q, busy_d;
  logic               tx_done_q, tx_done_d;
  logic               underrun_q, underrun_d;
  logic               pay_ready_q, pay_ready_d;
  logic [HDR_W-1:0]   hdr;
  logic [3:0]         crc_idx;
  logic               bit_end;
  logic               take_pay;
  logic               finish;

  // One bit-serial step of the x^16+x^12+x^5+1 header CRC.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fcnt_q      <= '0;
      pcnt_q      <= '0;
      len_q       <= '0;
      crc_q       <= CRC_INIT;
      tx_bit_q    <= 1'b0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      tx_done_q   <= 1'b0;
      underrun_q  <= 1'b0;
      pay_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fcnt_q      <= fcnt_d;
      pcnt_q      <= pcnt_d;
      len_q       <= len_d;
      crc_q       <= crc_d;
      tx_bit_q    <= tx_bit_d;
      tx_valid_q  <= tx_valid_d;
      busy_q      <= busy_d;
      tx_done_q   <= tx_done_d;
      underrun_q  <= underrun_d;
      pay_ready_q <= pay_ready_d;
    end
  end

  // Next state and next outputs; a new bit is chosen only at the end of a bit period.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fcnt_d      = fcnt_q;
    pcnt_d      = pcnt_q;
    len_d       = len_q;
    crc_d       = crc_q;
    tx_bit_d    = tx_bit_q;
    busy_d      = busy_q;
    tx_valid_d  = 1'b0;
    tx_done_d   = 1'b0;
    underrun_d  = 1'b0;
    pay_ready_d = 1'b0;
    take_pay    = 1'b0;
    finish      = 1'b0;
    fcnt_inc    = fcnt_q + 8'd1;
    hdr         = {len_q, SERVICE_VAL, SIGNAL_VAL};
    crc_nxt     = crc_step(crc_q, tx_bit_q);
    crc_idx     = 4'd15 - fcnt_inc[3:0];
    bit_end     = (cnt_q == CNT_LAST);

    if (state_q == IDLE) begin
      if (bus.start) begin
        state_d    = SYNC;
        len_d      = bus.length_us;
        busy_d     = 1'b1;
        tx_valid_d = 1'b1;
        tx_bit_d   = 1'b1;
        cnt_d      = '0;
        fcnt_d     = '0;
        crc_d      = CRC_INIT;
      end
    end else if (!bit_end) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d      = '0;
      fcnt_d     = fcnt_inc;
      tx_valid_d = 1'b1;
      case (state_q)
        SYNC: begin
          if (fcnt_q == SYNC_LAST) begin
            state_d  = SFD;
            fcnt_d   = '0;
            tx_bit_d = SFD_VAL[0];
          end else begin
            tx_bit_d = 1'b1;
          end
        end
        SFD: begin
          if (fcnt_q == 8'd15) begin
            state_d  = HDR;
            fcnt_d   = '0;
            tx_bit_d = hdr[0];
          end else begin
            tx_bit_d = SFD_VAL[fcnt_inc[3:0]];
          end
        end
        HDR: begin
          crc_d = crc_nxt;
          if (fcnt_q == 8'd31) begin
            state_d  = CRC;
            fcnt_d   = '0;
            tx_bit_d = ~crc_nxt[15];
          end else begin
            tx_bit_d = hdr[fcnt_inc[4:0]];
          end
        end
        CRC: begin
          if (fcnt_q == 8'd15) begin
            fcnt_d = '0;
            if (len_q == 16'd0) begin
              finish = 1'b1;
            end else begin
              state_d  = PAY;
              pcnt_d   = '0;
              take_pay = 1'b1;
            end
          end else begin
            tx_bit_d = ~crc_q[crc_idx];
          end
        end
        PAY: begin
          if (pcnt_q == len_q - 16'd1) begin
            finish = 1'b1;
          end else begin
            pcnt_d   = pcnt_q + 16'd1;
            take_pay = 1'b1;
          end
        end
        default: begin
          state_d    = IDLE;
          busy_d     = 1'b0;
          tx_valid_d = 1'b0;
        end
      endcase

      // Payload boundary: consume a source bit, or abort the frame if none is ready.
      if (take_pay) begin
        if (bus.pay_valid) begin
          tx_bit_d    = bus.pay_bit;
          pay_ready_d = 1'b1;
        end else begin
          underrun_d = 1'b1;
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end
      end

      if (finish) begin
        tx_valid_d = 1'b0;
        tx_done_d  = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
    end
  end

  assign bus.tx_bit    = tx_bit_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.busy      = busy_q;
  assign bus.tx_done   = tx_done_q;
  assign bus.underrun  = underrun_q;
  assign bus.pay_ready = pay_ready_q;

endmodule

// File: tb/tb_plcp_preamble_tx.sv
// Bench for plcp_preamble_tx: table-driven frames, hand-written reset/chain
// sequences and random frames against a frame-level reference model.
module tb_plcp_preamble_tx;

  localparam int unsigned BP = 4;
  localparam int unsigned SL = 128;
  localparam logic [15:0] SFD_V = 16'hF3A0;

  typedef struct {
    logic [15:0] len;
    int          avail;
    bit          fixed;
    int          nbits;
    bit          done;
    bit          under;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  plcp_preamble_tx_if bus();

  plcp_preamble_tx #(.BIT_PERIOD(BP), .SYNC_LEN(SL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int cyc = 0;
  int t_start = 32'h3FFF_FFFF;
  int checks = 0;
  int failures = 0;

  bit pay_src[$];
  bit exp_q[$];
  bit act_b[$];
  int act_c[$];
  int src_avail = 0;
  int pr_cnt = 0, done_cnt = 0, under_cnt = 0, stab_err = 0;
  int pr_base = 0, act_base = 0, done_base = 0, under_base = 0, stab_base = 0;
  int end_cyc;
  bit end_done, end_under;
  bit fixed_pay [8];
  bit sfd_seq [16];
  bit hdr_seq [32];
  vec_t tbl [6];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor and payload source, both on the falling edge.
  initial begin
    int idx;
    logic last_bit;
    last_bit = 1'b0;
    bus.pay_bit = 1'b0;
    bus.pay_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (cyc >= t_start) begin
        if (bus.tx_valid) begin
          act_b.push_back(bus.tx_bit);
          act_c.push_back(cyc);
        end else if (bus.busy && bus.tx_bit !== last_bit) begin
          stab_err++;
        end
        if (bus.tx_done) done_cnt++;
        if (bus.underrun) under_cnt++;
        if (bus.pay_ready) pr_cnt++;
      end
      last_bit = bus.tx_bit;
      idx = pr_cnt - pr_base;
      bus.pay_valid = (idx < src_avail);
      bus.pay_bit = (idx < src_avail && idx < pay_src.size()) ? pay_src[idx] : 1'($urandom);
    end
  end

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input bit b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // Whole expected bit stream of one frame.
  task automatic build_exp(input logic [15:0] len, input int avail);
    logic [31:0] hdr;
    logic [15:0] c;
    int n;
    exp_q.delete();
    for (int i = 0; i < int'(SL); i++) exp_q.push_back(1'b1);
    for (int i = 0; i < 16; i++) exp_q.push_back(SFD_V[i]);
    hdr = {len, 8'h00, 8'h0A};
    c = 16'hFFFF;
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back(hdr[i]);
      c = crc_upd(c, hdr[i]);
    end
    for (int i = 15; i >= 0; i--) exp_q.push_back(~c[i]);
    n = (avail < int'(len)) ? avail : int'(len);
    for (int i = 0; i < n; i++) exp_q.push_back(pay_src[i]);
  endtask

  // Called at posedge+1; drives start for the current cycle.
  task automatic start_frame(input logic [15:0] len, input int avail, input bit fixed);
    pay_src.delete();
    for (int i = 0; i < avail; i++) pay_src.push_back(fixed ? fixed_pay[i % 8] : 1'($urandom));
    src_avail = avail;
    pr_base = pr_cnt;
    act_base = act_b.size();
    done_base = done_cnt;
    under_base = under_cnt;
    stab_base = stab_err;
    build_exp(len, avail);
    bus.start = 1'b1;
    bus.length_us = len;
    t_start = cyc + 1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.length_us = 16'($urandom);
  endtask

  task automatic wait_end(input int budget);
    int n;
    n = 0;
    while (!(bus.tx_done || bus.underrun) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    end_cyc = cyc;
    end_done = bus.tx_done;
    end_under = bus.underrun;
    chk(n < budget, "end_timeout", n, budget);
    chk(bus.busy == 1'b0, "busy_at_end", int'(bus.busy), 0);
  endtask

  task automatic check_frame(input string name, input int nbits, input bit exp_done,
                             input bit exp_under, input bit tail);
    int nb, mism, terr;
    nb = act_b.size() - act_base;
    mism = 0;
    terr = 0;
    chk(nb == nbits, {name, "_nbits"}, nb, nbits);
    for (int k = 0; k < nb && k < exp_q.size(); k++)
      if (act_b[act_base + k] !== exp_q[k]) mism++;
    chk(mism == 0 && nb == exp_q.size(), {name, "_bits"}, mism, 0);
    for (int k = 0; k < nb; k++)
      if (act_c[act_base + k] != t_start + k * int'(BP)) terr++;
    chk(terr == 0, {name, "_strobe_timing"}, terr, 0);
    chk(end_done == exp_done, {name, "_tx_done"}, int'(end_done), int'(exp_done));
    chk(end_under == exp_under, {name, "_underrun"}, int'(end_under), int'(exp_under));
    chk(end_cyc == t_start + nbits * int'(BP), {name, "_end_cycle"}, end_cyc - t_start, nbits * int'(BP));
    chk(pr_cnt - pr_base == nbits - 192, {name, "_pay_ready"}, pr_cnt - pr_base, nbits - 192);
    chk(stab_err - stab_base == 0, {name, "_bit_stable"}, stab_err - stab_base, 0);
    if (tail) begin
      repeat (3 * BP) begin
        @(posedge clk); #1;
      end
      chk(act_b.size() - act_base == nb, {name, "_no_extra_valid"}, act_b.size() - act_base, nb);
      chk(done_cnt - done_base == int'(exp_done), {name, "_done_pulses"}, done_cnt - done_base, int'(exp_done));
      chk(under_cnt - under_base == int'(exp_under), {name, "_under_pulses"}, under_cnt - under_base, int'(exp_under));
      chk(bus.busy == 1'b0, {name, "_busy_after"}, int'(bus.busy), 0);
    end
  endtask

  task automatic check_idle(input string name);
    logic [5:0] outs;
    outs = {bus.tx_bit, bus.tx_valid, bus.busy, bus.tx_done, bus.underrun, bus.pay_ready};
    chk(outs == 6'b0, {name, "_outputs"}, int'(outs), 0);
    chk(dut.crc_q == 16'hFFFF, {name, "_crc_reg"}, int'(dut.crc_q), 16'hFFFF);
    chk(dut.cnt_q == 8'd0 && dut.fcnt_q == 8'd0, {name, "_counters"},
        int'({dut.cnt_q, dut.fcnt_q}), 0);
  endtask

  initial begin
    int nb, mism, n, len, avail, t0;
    logic [15:0] c;

    fixed_pay = '{1, 0, 1, 1, 0, 0, 1, 0};
    sfd_seq   = '{0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0, 0, 1, 1, 1, 1};
    hdr_seq   = '{0, 1, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,
                  0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0};
    tbl[0] = '{16'd8,     8,   1'b1, 200, 1'b1, 1'b0};
    tbl[1] = '{16'h0100,  256, 1'b0, 448, 1'b1, 1'b0};
    tbl[2] = '{16'd0,     0,   1'b0, 192, 1'b1, 1'b0};
    tbl[3] = '{16'd5,     2,   1'b0, 194, 1'b0, 1'b1};
    tbl[4] = '{16'd1,     1,   1'b0, 193, 1'b1, 1'b0};
    tbl[5] = '{16'd3,     0,   1'b0, 192, 1'b0, 1'b1};

    bus.start = 1'b0;
    bus.length_us = 16'd0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Table-driven frames.
    for (int i = 0; i < 6; i++) begin
      start_frame(tbl[i].len, tbl[i].avail, tbl[i].fixed);
      wait_end((tbl[i].nbits + 4) * int'(BP) + 20);
      check_frame($sformatf("vec%0d", i), tbl[i].nbits, tbl[i].done, tbl[i].under, 1'b1);
      nb = act_b.size() - act_base;
      if (i == 0) begin
        mism = (nb >= 192) ? 0 : 16;
        for (int k = 0; k < 16 && nb >= 192; k++)
          if (act_b[act_base + 128 + k] !== sfd_seq[k]) mism++;
        chk(mism == 0, "vec0_sfd_pattern", mism, 0);
      end
      if (i == 1) begin
        mism = (nb >= 192) ? 0 : 32;
        for (int k = 0; k < 32 && nb >= 192; k++)
          if (act_b[act_base + 144 + k] !== hdr_seq[k]) mism++;
        chk(mism == 0, "vec1_header_pattern", mism, 0);
        c = 16'hFFFF;
        for (int k = 144; k < 192 && nb >= 192; k++) c = crc_upd(c, act_b[act_base + k]);
        chk(c == 16'h1D0F, "vec1_crc_residue", int'(c), 16'h1D0F);
      end
    end

    // Start during SFD is ignored; reset during HDR kills the frame.
    start_frame(16'd4, 4, 1'b0);
    t0 = t_start;
    while (cyc < t0 + 135 * int'(BP) + 1) begin
      @(posedge clk); #1;
    end
    bus.start = 1'b1;
    bus.length_us = 16'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (cyc < t0 + 150 * int'(BP) + 2) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_idle("mid_reset");
    nb = act_b.size() - act_base;
    chk(nb == 151, "mid_reset_nbits", nb, 151);
    mism = 0;
    for (int k = 0; k < nb && k < exp_q.size(); k++)
      if (act_b[act_base + k] !== exp_q[k]) mism++;
    chk(mism == 0, "mid_reset_prefix_bits", mism, 0);
    repeat (20) begin
      @(posedge clk); #1;
    end
    chk(act_b.size() - act_base == nb, "mid_reset_no_valid", act_b.size() - act_base, nb);
    chk(done_cnt - done_base == 0, "mid_reset_no_done", done_cnt - done_base, 0);
    check_idle("mid_reset_later");

    start_frame(16'd6, 6, 1'b0);
    wait_end(200 * int'(BP));
    check_frame("after_reset", 198, 1'b1, 1'b0, 1'b1);

    // Start in the tx_done cycle chains straight into the next frame.
    start_frame(16'd2, 2, 1'b0);
    wait_end(200 * int'(BP));
    check_frame("chain_a", 194, 1'b1, 1'b0, 1'b0);
    start_frame(16'd3, 3, 1'b0);
    wait_end(200 * int'(BP));
    check_frame("chain_b", 195, 1'b1, 1'b0, 1'b1);

    // Random frames, some starved of payload.
    for (int r = 0; r < 6; r++) begin
      len = int'($urandom_range(0, 20));
      avail = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len)) : len;
      n = 192 + ((avail < len) ? avail : len);
      start_frame(16'(len), avail, 1'b0);
      wait_end((n + 4) * int'(BP) + 20);
      check_frame($sformatf("rand%0d", r), n, avail >= len, avail < len, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
